// File: rtl/spi_target.sv
// SPI mode-0 target: synchronises SCK/CS/COPI into clk_i, shifts 8-bit frames,
// and exchanges bytes through a ready/valid rx holding register and tx port.
//
// state | meaning
// IDLE  | chip select released, CIPO parked high, edges ignored
// SHIFT | chip select asserted, shifting bytes in and out
module spi_target #(
    parameter logic [7:0] FillByte   = 8'hFF,
    parameter int         SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sck_i,
    input  logic       spi_cs_ni,
    input  logic       spi_copi_i,
    output logic       spi_cipo_o,
    output logic       spi_cipo_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       active_o,
    output logic       rx_overflow_o,
    output logic       tx_underrun_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SyncStages-1:0] sck_sync, cs_sync, copi_sync, sync_fill;
    logic                  sck_s, cs_s, copi_s;
    logic                  sck_prev, cs_prev, cs_armed;
    logic                  sck_rise, sck_fall, cs_fall, cs_rise;

    logic [7:0] tx_shift, rx_shift;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic       load_tx;

    assign sck_s  = sck_sync[SyncStages-1];
    assign cs_s   = cs_sync[SyncStages-1];
    assign copi_s = copi_sync[SyncStages-1];

    // A CS already low when reset releases is not a fresh edge: only arm the
    // falling-edge detector once a genuinely sampled high has been seen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            copi_sync <= '0;
            sync_fill <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
            cs_armed  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SyncStages-2:0], spi_sck_i};
            cs_sync   <= {cs_sync[SyncStages-2:0], spi_cs_ni};
            copi_sync <= {copi_sync[SyncStages-2:0], spi_copi_i};
            sync_fill <= {sync_fill[SyncStages-2:0], 1'b1};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
            if (sync_fill[SyncStages-1] && cs_s) begin
                cs_armed <= 1'b1;
            end
        end
    end

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = cs_armed & cs_prev & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A byte completing as CS rises is still delivered, but no tx byte is
    // fetched for a frame that has already ended.
    assign load_tx = ((state_q == IDLE) && cs_fall) || (byte_done && (state_q == SHIFT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            byte_done  <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            byte_done <= 1'b0;

            if (load_tx) begin
                tx_shift <= tx_valid_i ? tx_data_i : FillByte;
            end else if ((state_q == SHIFT) && sck_fall && (bit_cnt != 3'd0)) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            if ((state_q == IDLE) && cs_fall) begin
                bit_cnt <= '0;
            end else if (state_q == SHIFT) begin
                if (sck_rise) begin
                    rx_shift  <= {rx_shift[6:0], copi_s};
                    bit_cnt   <= bit_cnt + 3'd1;
                    byte_done <= (bit_cnt == 3'd7);
                end
                if (cs_rise) begin
                    bit_cnt <= '0;
                end
            end

            if (byte_done && (!rx_valid_o || rx_ready_i)) begin
                rx_data_o  <= rx_shift;
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    assign tx_ready_o    = load_tx & tx_valid_i;
    assign tx_underrun_o = load_tx & ~tx_valid_i;
    assign rx_overflow_o = byte_done & rx_valid_o & ~rx_ready_i;
    assign active_o      = (state_q == SHIFT);
    assign spi_cipo_en_o = active_o;
    assign spi_cipo_o    = active_o ? tx_shift[7] : 1'b1;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives SPI frames as the controller, checks
// CIPO bits, rx bytes, handshake pulses and reset behaviour against expectations.
module tb_spi_target;

    localparam int HALF = 4;
    localparam int SYNC = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       spi_sck_i, spi_cs_ni, spi_copi_i;
    logic       spi_cipo_o, spi_cipo_en_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o, active_o, rx_overflow_o, tx_underrun_o;

    int n_cmp = 0;
    int n_fail = 0;
    int cnt_rdy = 0, cnt_und = 0, cnt_ovf = 0;
    int s_rdy, s_und, s_ovf;
    int rx_seen = 0, n_exp = 0;
    logic [7:0] exp_rx[32];
    logic [7:0] feed[$];

    spi_target #(.FillByte(8'hFF), .SyncStages(SYNC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .spi_sck_i(spi_sck_i), .spi_cs_ni(spi_cs_ni), .spi_copi_i(spi_copi_i),
        .spi_cipo_o(spi_cipo_o), .spi_cipo_en_o(spi_cipo_en_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .active_o(active_o), .rx_overflow_o(rx_overflow_o), .tx_underrun_o(tx_underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic expect_rx(input logic [7:0] b);
        exp_rx[n_exp] = b;
        n_exp++;
    endtask

    task automatic snap();
        s_rdy = cnt_rdy;
        s_und = cnt_und;
        s_ovf = cnt_ovf;
    endtask

    // Controller side of a frame. Bits are MSB-first from the top of the words;
    // end_on_rise releases CS together with the final SCK rise.
    task automatic run_frame(input int nbits, input logic [31:0] copi_w,
                             input logic [31:0] cipo_w, input bit end_on_rise,
                             input int pulse_bit);
        spi_copi_i = copi_w[31];
        spi_cs_ni  = 1'b0;
        cyc(6);
        for (int i = 0; i < nbits; i++) begin
            chk("cipo_bit", 32'(spi_cipo_o), 32'(cipo_w[31-i]));
            spi_sck_i = 1'b1;
            if (end_on_rise && i == nbits - 1) spi_cs_ni = 1'b1;
            if (i == pulse_bit) begin
                cyc(SYNC + 1);
                rx_ready_i = 1'b1;
                cyc(1);
                rx_ready_i = 1'b0;
                cyc(HALF - SYNC - 2);
            end else begin
                cyc(HALF);
            end
            if (!(end_on_rise && i == nbits - 1)) begin
                spi_sck_i = 1'b0;
                if (i + 1 < nbits) spi_copi_i = copi_w[30-i];
                cyc(HALF);
            end
        end
        spi_cs_ni = 1'b1;
        spi_sck_i = 1'b0;
        cyc(8);
    endtask

    initial begin
        rst_i      = 1'b1;
        spi_sck_i  = 1'b0;
        spi_cs_ni  = 1'b1;
        spi_copi_i = 1'b0;
        rx_ready_i = 1'b1;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        fork
            begin : monitor
                bit took;
                forever begin
                    @(negedge clk_i);
                    #1;
                    took = 1'b0;
                    if (rst_i) begin
                        chk("reset_outputs",
                            32'({rx_valid_o, tx_ready_o, active_o, spi_cipo_en_o,
                                 rx_overflow_o, tx_underrun_o, spi_cipo_o, rx_data_o}),
                            32'h0000_0100);
                    end else begin
                        chk("cipo_en_eq_active", 32'(spi_cipo_en_o), 32'(active_o));
                        if (!active_o) chk("cipo_idle_high", 32'(spi_cipo_o), 32'd1);
                        if (tx_ready_o) begin
                            chk("tx_ready_needs_valid", 32'(tx_valid_i), 32'd1);
                            cnt_rdy++;
                            took = 1'b1;
                        end
                        if (tx_underrun_o) cnt_und++;
                        if (rx_overflow_o) cnt_ovf++;
                        if (rx_valid_o && rx_ready_i) begin
                            if (rx_seen < n_exp) begin
                                chk("rx_byte", 32'(rx_data_o), 32'(exp_rx[rx_seen]));
                            end else begin
                                n_cmp++;
                                n_fail++;
                                $display("FAIL rx_unexpected: got %0h, no byte expected", rx_data_o);
                            end
                            rx_seen++;
                        end
                    end
                    @(posedge clk_i);
                    #1;
                    if (took && feed.size() > 0) void'(feed.pop_front());
                    tx_valid_i = (feed.size() > 0);
                    tx_data_i  = (feed.size() > 0) ? feed[0] : 8'h00;
                end
            end
            begin : main
                cyc(3);
                chk("reset_cipo", 32'(spi_cipo_o), 32'd1);
                chk("reset_cipo_en", 32'(spi_cipo_en_o), 32'd0);
                rst_i = 1'b0;
                cyc(6);

                // single byte: A5 out, 3C in
                rx_ready_i = 1'b0;
                feed.push_back(8'hA5);
                cyc(2);
                snap();
                expect_rx(8'h3C);
                run_frame(8, 32'h3C00_0000, 32'hA500_0000, 1'b1, -1);
                chk("single_tx_ready", 32'(cnt_rdy - s_rdy), 32'd1);
                chk("single_underrun", 32'(cnt_und - s_und), 32'd0);
                chk("single_rx_valid", 32'(rx_valid_o), 32'd1);
                chk("single_rx_data", 32'(rx_data_o), 32'h3C);
                rx_ready_i = 1'b1;
                cyc(2);
                chk("single_rx_count", 32'(rx_seen), 32'(n_exp));
                chk("single_rx_cleared", 32'(rx_valid_o), 32'd0);

                // underrun: three bytes with no tx data queued
                snap();
                expect_rx(8'h01); expect_rx(8'h02); expect_rx(8'h03);
                run_frame(24, 32'h0102_0300, 32'hFFFF_FF00, 1'b1, -1);
                chk("underrun_count", 32'(cnt_und - s_und), 32'd3);
                chk("underrun_tx_ready", 32'(cnt_rdy - s_rdy), 32'd0);
                chk("underrun_rx_count", 32'(rx_seen), 32'(n_exp));

                // overflow: second byte dropped while first is held
                rx_ready_i = 1'b0;
                snap();
                run_frame(16, 32'h1122_0000, 32'hFFFF_0000, 1'b1, -1);
                chk("ovf_count", 32'(cnt_ovf - s_ovf), 32'd1);
                chk("ovf_rx_data_kept", 32'(rx_data_o), 32'h11);
                chk("ovf_rx_valid", 32'(rx_valid_o), 32'd1);
                expect_rx(8'h11);
                rx_ready_i = 1'b1;
                cyc(1);
                rx_ready_i = 1'b0;
                cyc(2);
                chk("ovf_rx_count", 32'(rx_seen), 32'(n_exp));
                chk("ovf_rx_cleared", 32'(rx_valid_o), 32'd0);

                // accept in the same cycle the second byte lands
                snap();
                expect_rx(8'h11); expect_rx(8'h22);
                run_frame(16, 32'h1122_0000, 32'hFFFF_0000, 1'b1, 15);
                chk("simul_no_ovf", 32'(cnt_ovf - s_ovf), 32'd0);
                chk("simul_rx_data", 32'(rx_data_o), 32'h22);
                chk("simul_rx_valid", 32'(rx_valid_o), 32'd1);
                chk("simul_first_taken", 32'(rx_seen), 32'(n_exp - 1));
                rx_ready_i = 1'b1;
                cyc(2);
                chk("simul_rx_count", 32'(rx_seen), 32'(n_exp));

                // abort after 5 bits, then a clean 7E frame
                snap();
                run_frame(5, 32'hA800_0000, 32'hF800_0000, 1'b0, -1);
                chk("abort_no_rx", 32'(rx_seen), 32'(n_exp));
                chk("abort_rx_valid", 32'(rx_valid_o), 32'd0);
                chk("abort_underrun", 32'(cnt_und - s_und), 32'd1);
                chk("abort_no_ovf", 32'(cnt_ovf - s_ovf), 32'd0);
                expect_rx(8'h7E);
                run_frame(8, 32'h7E00_0000, 32'hFF00_0000, 1'b1, -1);
                chk("after_abort_rx", 32'(rx_seen), 32'(n_exp));

                // reset after bit 3, CS still low at release
                spi_copi_i = 1'b1;
                spi_cs_ni  = 1'b0;
                cyc(6);
                repeat (3) begin
                    spi_sck_i = 1'b1;
                    cyc(HALF);
                    spi_sck_i = 1'b0;
                    cyc(HALF);
                end
                rst_i = 1'b1;
                cyc(1);
                chk("midrst_cipo_en", 32'(spi_cipo_en_o), 32'd0);
                chk("midrst_cipo", 32'(spi_cipo_o), 32'd1);
                chk("midrst_active", 32'(active_o), 32'd0);
                cyc(2);
                rst_i = 1'b0;
                snap();
                cyc(10);
                chk("postrst_idle", 32'(active_o), 32'd0);
                chk("postrst_no_load", 32'((cnt_rdy - s_rdy) + (cnt_und - s_und)), 32'd0);
                spi_cs_ni = 1'b1;
                cyc(6);
                expect_rx(8'h96);
                run_frame(8, 32'h9600_0000, 32'hFF00_0000, 1'b1, -1);
                chk("postrst_rx", 32'(rx_seen), 32'(n_exp));
                chk("postrst_underrun", 32'(cnt_und - s_und), 32'd1);

                // back-to-back 4 bytes at minimum SCK period
                feed.push_back(8'hC1); feed.push_back(8'hC2);
                feed.push_back(8'hC3); feed.push_back(8'hC4);
                cyc(2);
                snap();
                expect_rx(8'h5A); expect_rx(8'h0F); expect_rx(8'hF0); expect_rx(8'h81);
                run_frame(32, 32'h5A0F_F081, 32'hC1C2_C3C4, 1'b1, -1);
                chk("b2b_tx_ready", 32'(cnt_rdy - s_rdy), 32'd4);
                chk("b2b_underrun", 32'(cnt_und - s_und), 32'd0);
                chk("b2b_rx_count", 32'(rx_seen), 32'(n_exp));

                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        join_any
    end

endmodule
